// File: rtl/mem_access_wb.sv
// Memory-access / writeback stage: single-outstanding data-memory handshake with pipeline stall.
// Optional MEM_ACCESS_TIMEOUT_EN adds an 8-bit access timeout that raises a sticky dmem_err.
module mem_access_wb (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        MemWrite,
    input  logic [63:0] AluOut,
    input  logic [63:0] DataOut,
    input  logic [4:0]  Rd_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        dmem_err
);
    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic       reg_write;
        logic       is_load;
        logic [4:0] rd;
    } pend_t;

    state_t state;
    pend_t  pend;
    logic   memop;
    logic   timeout;

    assign memop = MemtoReg | MemWrite;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0] to_cnt;

    // to_cnt counts finished no-ack cycles, so 254 means this is the 255th ACCESS cycle
    assign timeout = (state == ACCESS) && !dmem_ack && (to_cnt == 8'd254);

    always_ff @(posedge clk) begin
        if (reset)
            to_cnt <= 8'd0;
        else if (state == IDLE)
            to_cnt <= 8'd0;
        else if (!dmem_ack)
            to_cnt <= to_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            dmem_err <= 1'b0;
        else if (timeout)
            dmem_err <= 1'b1;
    end
`else
    assign timeout  = 1'b0;
    assign dmem_err = 1'b0;
`endif

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = memop;
                ACCESS:  stall = !dmem_ack && !timeout;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pend         <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 64'd0;
            dmem_wdata   <= 64'd0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        // store wins when both flags are set
                        state          <= ACCESS;
                        dmem_req       <= 1'b1;
                        dmem_we        <= MemWrite;
                        dmem_addr      <= AluOut;
                        dmem_wdata     <= DataOut;
                        pend.reg_write <= RegWrite;
                        pend.is_load   <= !MemWrite;
                        pend.rd        <= Rd_out;
                        wb_reg_write   <= 1'b0;
                    end else begin
                        wb_reg_write   <= RegWrite && (Rd_out != 5'd0);
                        wb_rd          <= Rd_out;
                        wb_data        <= AluOut;
                    end
                end
                ACCESS: begin
                    wb_reg_write <= 1'b0;
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        if (pend.is_load) begin
                            wb_reg_write <= pend.reg_write && (pend.rd != 5'd0);
                            wb_rd        <= pend.rd;
                            wb_data      <= dmem_rdata;
                        end
                    end else if (timeout) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_wb.sv
// Directed bench for mem_access_wb: writebacks go through an expected-queue checked by a monitor.
module tb_mem_access_wb;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite, MemtoReg, MemWrite;
    logic [63:0] AluOut, DataOut;
    logic [4:0]  Rd_out;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        stall, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        dmem_err;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    mem_access_wb dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .AluOut(AluOut), .DataOut(DataOut), .Rd_out(Rd_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every writeback the DUT presents must match the oldest expected entry.
    always @(negedge clk) begin
        wb_t e;
        if (wb_reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h expected no writeback", wb_rd, wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic nop_inputs();
        RegWrite = 1'b0; MemtoReg = 1'b0; MemWrite = 1'b0;
        AluOut = 64'd0; DataOut = 64'd0; Rd_out = 5'd0;
    endtask

    task automatic alu_op(input logic rw, input logic [4:0] rd, input logic [63:0] val);
        @(negedge clk);
        RegWrite = rw; MemtoReg = 1'b0; MemWrite = 1'b0; Rd_out = rd; AluOut = val;
        #1 chk("stall_alu", 64'(stall), 64'd0);
        if (rw && rd != 5'd0) exp_q.push_back('{rd, val});
        @(negedge clk);
        nop_inputs();
    endtask

    // One memory op: issue, `waits` cycles with no ack, then ack. Returns stalled cycles.
    task automatic do_mem(input bit st, input logic rw, input logic [4:0] rd,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input int waits, output int stalls);
        stalls = 0;
        @(negedge clk);
        MemWrite = st; MemtoReg = !st; RegWrite = rw; Rd_out = rd; AluOut = addr; DataOut = wdata;
        #1 chk("stall_issue", 64'(stall), 64'd1);
        if (stall) stalls++;
        if (!st && rw && rd != 5'd0) exp_q.push_back('{rd, rdata});
        @(negedge clk);
        // inputs are don't-care while ACCESS is in progress
        AluOut = {$urandom, $urandom}; DataOut = {$urandom, $urandom}; Rd_out = 5'($urandom);
        #1;
        for (int i = 0; i < waits; i++) begin
            chk("dmem_req_hold", 64'(dmem_req), 64'd1);
            chk("dmem_addr_hold", dmem_addr, addr);
            chk("dmem_we_hold", 64'(dmem_we), 64'(st));
            if (st) chk("dmem_wdata_hold", dmem_wdata, wdata);
            if (stall) stalls++;
            @(negedge clk);
            #1;
        end
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1 chk("stall_on_ack", 64'(stall), 64'd0);
        chk("dmem_req_at_ack", 64'(dmem_req), 64'd1);
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 64'd0;
        nop_inputs();
        chk("dmem_req_drop", 64'(dmem_req), 64'd0);
    endtask

    initial begin
        int s;
        int n;
        reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 64'd0;
        nop_inputs();
        MemtoReg = 1'b1;   // a pending load must not stall while in reset
        repeat (2) @(negedge clk);
        #1 chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_err", 64'(dmem_err), 64'd0);
        nop_inputs();
        @(negedge clk);
        reset = 1'b0;

        alu_op(1'b1, 5'd5, 64'h1234);
        alu_op(1'b1, 5'd0, 64'hFFFF);            // x0 never written
        alu_op(1'b0, 5'd6, 64'h5555);            // RegWrite low
        alu_op(1'b1, 5'd31, 64'hFEDC_BA98_7654_3210);

        do_mem(1'b0, 1'b1, 5'd7, 64'h100, 64'd0, 64'hDEADBEEF, 3, s);
        chk("load_stall_cycles", 64'(s), 64'd4);
        do_mem(1'b1, 1'b1, 5'd8, 64'h200, 64'hAA55, 64'h1111, 2, s);
        chk("store_stall_cycles", 64'(s), 64'd3);
        do_mem(1'b0, 1'b1, 5'd0, 64'h300, 64'd0, 64'hCAFE, 1, s);
        do_mem(1'b0, 1'b1, 5'd12, 64'h308, 64'd0, 64'h0123_4567_89AB_CDEF, 0, s);
        chk("load_noack_wait_stalls", 64'(s), 64'd1);
        do_mem(1'b1, 1'b0, 5'd0, 64'h310, 64'h9999, 64'd0, 0, s);   // back-to-back memops
        // both flags set: treated as a store, no writeback
        @(negedge clk);
        MemWrite = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; Rd_out = 5'd3; AluOut = 64'h318; DataOut = 64'h42;
        @(negedge clk);
        nop_inputs();
        #1 chk("both_flags_we", 64'(dmem_we), 64'd1);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        alu_op(1'b1, 5'd10, 64'hABCD);

        // ack on the 255th ACCESS cycle completes normally
        do_mem(1'b0, 1'b1, 5'd4, 64'h400, 64'd0, 64'h7777, 254, s);
        #1 chk("err_after_late_ack", 64'(dmem_err), 64'd0);

        // reset in 2nd ACCESS cycle, coinciding with ack
        @(negedge clk);
        MemtoReg = 1'b1; RegWrite = 1'b1; Rd_out = 5'd9; AluOut = 64'h500;
        @(negedge clk);
        nop_inputs();
        @(negedge clk);
        reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'h55;
        #1 chk("stall_in_reset", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_req", 64'(dmem_req), 64'd0);
        chk("abort_addr", dmem_addr, 64'd0);
        chk("abort_we", 64'(dmem_we), 64'd0);
        chk("abort_wb_rd", 64'(wb_rd), 64'd0);
        chk("abort_wb_data", wb_data, 64'd0);
        @(negedge clk);                          // ack still high while IDLE
        dmem_ack = 1'b0;
        chk("idle_ack_req", 64'(dmem_req), 64'd0);
        chk("idle_ack_wb_data", wb_data, 64'd0);

        // timeout: store with no ack
        @(negedge clk);
        MemWrite = 1'b1; AluOut = 64'h600; DataOut = 64'h77;
        @(negedge clk);
        nop_inputs();
        n = 0;
        while (dmem_req && n < 300) begin
            n++;
`ifdef MEM_ACCESS_TIMEOUT_EN
            if (n == 255) begin
                #1 chk("stall_timeout_cycle", 64'(stall), 64'd0);
            end
`endif
            @(negedge clk);
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        chk("timeout_req_cycles", 64'(n), 64'd255);
        chk("timeout_err_set", 64'(dmem_err), 64'd1);
        alu_op(1'b1, 5'd2, 64'h22);
        chk("timeout_err_sticky", 64'(dmem_err), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("timeout_err_cleared", 64'(dmem_err), 64'd0);
`else
        chk("no_timeout_req_cycles", 64'(n), 64'd300);
        chk("no_timeout_err", 64'(dmem_err), 64'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("no_timeout_req_drop", 64'(dmem_req), 64'd0);
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
